// File: rtl/motor_mode_sched.sv
// Drive-mode sequencer between the decision logic and the motor driver:
// inserts dead-time braking on direction reversal, enforces dwell and watchdog stop.
module motor_mode_sched #(
  parameter int CNT_W       = 32,
  parameter int DEAD_CYCLES = 2_500_000,
  parameter int MIN_HOLD    = 1_000_000,
  parameter int TIMEOUT     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  output logic [2:0] mode,
  output logic       braking,
  output logic       timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CL_STOP,
    CL_FWD,
    CL_BACK,
    CL_SPINA,
    CL_SPINB
  } dir_class_t;

  function automatic dir_class_t dir_class(input logic [2:0] m);
    case (m)
      3'b011, 3'b101, 3'b110: dir_class = CL_FWD;
      3'b100:                 dir_class = CL_BACK;
      3'b001:                 dir_class = CL_SPINA;
      3'b010:                 dir_class = CL_SPINB;
      default:                dir_class = CL_STOP;
    endcase
  endfunction

  state_t           cur_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] brake_cnt;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_next;
  logic [2:0]       pending;
  logic             req_is_stop;
  logic             accept;
  logic             wd_fire;

  assign state = cur_state;

  // Stop requests are always welcome; running requests wait out the dwell and the brake.
  always_comb begin
    req_is_stop = (dir_class(req_mode) == CL_STOP);
    req_ready   = 1'b0;
    if (rst && enable)
      req_ready = req_is_stop || (cur_state == ST_STOP) ||
                  ((cur_state == ST_RUN) && (hold_cnt == '0));
    accept  = req_valid && req_ready;
    wd_next = req_valid ? '0 :
              ((wd_cnt == '1) ? wd_cnt : wd_cnt + CNT_W'(1));
    wd_fire = (cur_state != ST_STOP) && (wd_next >= CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_STOP;
      mode      <= 3'b000;
      braking   <= 1'b0;
      timeout   <= 1'b0;
      pending   <= 3'b000;
      hold_cnt  <= '0;
      brake_cnt <= '0;
      wd_cnt    <= '0;
    end else if (!enable) begin
      cur_state <= ST_STOP;
      mode      <= 3'b000;
      braking   <= 1'b0;
      pending   <= 3'b000;
      hold_cnt  <= '0;
      brake_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_fire || (accept && req_is_stop)) begin
        cur_state <= ST_STOP;
        mode      <= 3'b000;
        braking   <= 1'b0;
        pending   <= 3'b000;
        hold_cnt  <= '0;
        brake_cnt <= '0;
        if (wd_fire)
          timeout <= 1'b1;
      end else if (accept) begin
        timeout <= 1'b0;
        // Only a running mode can reverse; from STOP the new mode is applied directly.
        if ((cur_state == ST_RUN) && (dir_class(req_mode) != dir_class(mode))) begin
          cur_state <= ST_BRAKE;
          mode      <= 3'b000;
          braking   <= 1'b1;
          pending   <= req_mode;
          brake_cnt <= CNT_W'(DEAD_CYCLES - 1);
        end else begin
          cur_state <= ST_RUN;
          mode      <= req_mode;
          hold_cnt  <= CNT_W'(MIN_HOLD);
        end
      end else begin
        case (cur_state)
          ST_RUN: begin
            if (hold_cnt != '0)
              hold_cnt <= hold_cnt - CNT_W'(1);
          end
          ST_BRAKE: begin
            if (brake_cnt == '0) begin
              cur_state <= ST_RUN;
              mode      <= pending;
              braking   <= 1'b0;
              pending   <= 3'b000;
              hold_cnt  <= CNT_W'(MIN_HOLD);
            end else begin
              brake_cnt <= brake_cnt - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_mode_sched.sv
// Self-checking bench for motor_mode_sched: directed scenarios then random traffic,
// compared against a timestamp-based model of the sequencing rules.
module tb_motor_mode_sched;

  localparam int DEAD = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 20;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;
  logic [2:0] mode;
  logic       braking;
  logic       timeout;
  logic [1:0] state;

  int total;
  int bad;

  int         m_state;
  logic [2:0] m_mode;
  logic [2:0] m_pending;
  logic       m_timeout;
  int         cyc;
  int         hold_set;
  int         brake_set;
  int         idle;

  motor_mode_sched #(
    .CNT_W(32), .DEAD_CYCLES(DEAD), .MIN_HOLD(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
    .req_mode(req_mode), .req_ready(req_ready), .mode(mode),
    .braking(braking), .timeout(timeout), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dir_class(input logic [2:0] m);
    case (m)
      3'b011, 3'b101, 3'b110: return 1;
      3'b100:                 return 2;
      3'b001:                 return 3;
      3'b010:                 return 4;
      default:                return 0;
    endcase
  endfunction

  // Dwell and brake lengths are judged from the cycle stamps of when they began.
  function automatic logic model_ready(input logic en, input logic [2:0] m);
    if (!en) return 1'b0;
    if (dir_class(m) == 0) return 1'b1;
    if (m_state == 0) return 1'b1;
    return (m_state == 1) && ((cyc - hold_set) >= HOLD);
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_mode    = 3'b000;
    m_pending = 3'b000;
    m_timeout = 1'b0;
    cyc       = 0;
    hold_set  = 0;
    brake_set = 0;
    idle      = 0;
  endtask

  task automatic model_edge(input logic en, input logic v, input logic [2:0] m);
    logic rdy;
    logic expire;
    rdy    = model_ready(en, m);
    expire = (m_state == 2) && ((cyc - brake_set + 1) >= DEAD);
    cyc++;
    if (!en) begin
      m_state = 0; m_mode = 3'b000; m_pending = 3'b000; idle = 0;
    end else begin
      idle = v ? 0 : idle + 1;
      if (m_state != 0 && idle >= TMO) begin
        m_state = 0; m_mode = 3'b000; m_pending = 3'b000; m_timeout = 1'b1;
      end else if (v && rdy && dir_class(m) == 0) begin
        m_state = 0; m_mode = 3'b000; m_pending = 3'b000;
      end else if (v && rdy) begin
        m_timeout = 1'b0;
        if (m_state == 1 && dir_class(m) != dir_class(m_mode)) begin
          m_state = 2; m_mode = 3'b000; m_pending = m; brake_set = cyc;
        end else begin
          m_state = 1; m_mode = m; hold_set = cyc;
        end
      end else if (expire) begin
        m_state = 1; m_mode = m_pending; hold_set = cyc;
      end
    end
  endtask

  task automatic check_output(input string tag);
    logic [1:0] exp_state;
    logic       exp_brk;
    exp_state = 2'(m_state);
    exp_brk   = (m_state == 2);
    total++;
    assert (state === exp_state) else begin
      bad++; $error("FAIL %s state got=%0d want=%0d", tag, state, exp_state);
    end
    total++;
    assert (mode === m_mode) else begin
      bad++; $error("FAIL %s mode got=%b want=%b", tag, mode, m_mode);
    end
    total++;
    assert (braking === exp_brk) else begin
      bad++; $error("FAIL %s braking got=%b want=%b", tag, braking, exp_brk);
    end
    total++;
    assert (timeout === m_timeout) else begin
      bad++; $error("FAIL %s timeout got=%b want=%b", tag, timeout, m_timeout);
    end
  endtask

  task automatic check_ready(input string tag, input logic exp_rdy);
    total++;
    assert (req_ready === exp_rdy) else begin
      bad++; $error("FAIL %s req_ready got=%b want=%b", tag, req_ready, exp_rdy);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic v, input logic [2:0] m,
                                input string tag);
    @(negedge clk);
    enable = en; req_valid = v; req_mode = m;
    #1;
    check_ready(tag, model_ready(en, m));
    model_edge(en, v, m);
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check_ready("reset_ready", 1'b0);
      @(posedge clk);
      #1;
      model_reset();
      check_output("reset");
    end
  endtask

  task automatic repeat_stim(input int n, input logic en, input logic v,
                             input logic [2:0] m, input string tag);
    for (int i = 0; i < n; i++) apply_stimulus(en, v, m, tag);
  endtask

  initial begin
    int quiet;
    logic en_r, v_r;
    logic [2:0] m_r;
    total = 0; bad = 0; quiet = 0;
    rst = 1'b0; enable = 1'b1; req_valid = 1'b1; req_mode = 3'b011;
    model_reset();
    reset_cycles(3);
    rst = 1'b1;

    $display("[TB] dwell between same-class changes");
    apply_stimulus(1, 1, 3'b011, "accept_fwd");
    repeat_stim(10, 1, 1, 3'b101, "dwell_fwd");
    repeat_stim(9, 1, 0, 3'b000, "idle_a");

    $display("[TB] reversal brake");
    repeat_stim(7, 1, 1, 3'b100, "brake_back");
    repeat_stim(9, 1, 0, 3'b000, "idle_b");

    $display("[TB] stop during brake");
    apply_stimulus(1, 1, 3'b011, "brake_enter");
    apply_stimulus(1, 0, 3'b000, "brake_wait");
    apply_stimulus(1, 1, 3'b000, "brake_stop");
    repeat_stim(5, 1, 0, 3'b000, "after_stop");

    $display("[TB] watchdog");
    apply_stimulus(1, 1, 3'b001, "spina");
    repeat_stim(22, 1, 0, 3'b000, "starve");
    apply_stimulus(1, 1, 3'b011, "timeout_clear");

    $display("[TB] stop during dwell and mode 111");
    apply_stimulus(1, 1, 3'b000, "stop_dwell_a");
    apply_stimulus(1, 1, 3'b110, "run_110");
    apply_stimulus(1, 1, 3'b000, "stop_dwell_b");
    apply_stimulus(1, 1, 3'b111, "stop_111");

    $display("[TB] enable low mid brake, reset mid run");
    apply_stimulus(1, 1, 3'b101, "run_101");
    repeat_stim(9, 1, 0, 3'b000, "idle_c");
    apply_stimulus(1, 1, 3'b010, "brake_spinb");
    apply_stimulus(1, 0, 3'b000, "brake_hold");
    repeat_stim(3, 0, 1, 3'b011, "disabled");
    apply_stimulus(1, 1, 3'b011, "reenable");
    repeat_stim(2, 1, 0, 3'b000, "idle_d");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_output("async_rst");
    check_ready("async_rst_ready", 1'b0);
    reset_cycles(2);
    rst = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      en_r = ($urandom_range(0, 24) != 0);
      if (quiet > 0) begin
        v_r = 1'b0;
        quiet--;
      end else begin
        if ($urandom_range(0, 39) == 0) quiet = $urandom_range(15, 25);
        v_r = ($urandom_range(0, 9) < 6);
      end
      m_r = 3'($urandom_range(0, 7));
      apply_stimulus(en_r, v_r, m_r, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_mode_sched.md
Name: motor_mode_sched

Overview:
- Sequences the 3-bit drive mode consumed by the motor driver, sitting between the line-tracking/decision logic and the motor block.
- Accepts mode requests over a valid/ready handshake and applies three rules:
  - inserts a timed brake (mode 000) whenever wheel direction class reverses;
  - enforces a minimum dwell time between running-mode changes;
  - forces stop on request-starvation timeout or disable.

Parameters:
- CNT_W, 32, width of all internal counters.
- DEAD_CYCLES, 2_500_000, cycles mode is held at 000 on direction-class change (>=1).
- MIN_HOLD, 1_000_000, cycles after entering/changing a running mode before another non-stop request is accepted (0 = no dwell).
- TIMEOUT, 50_000_000, consecutive cycles without req_valid before forced stop (>=1).

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, drive enable; low forces stop.
- req_valid, input, 1, request present.
- req_mode, input, 3, requested motor mode.
- req_ready, output, 1, request accepted this cycle when req_valid & req_ready.
- mode, output, 3, registered mode to motor driver.
- braking, output, 1, high while in BRAKE.
- timeout, output, 1, sticky starvation flag.
- state, output, 2, 0=STOP, 1=RUN, 2=BRAKE.

Behaviour:
- Reset (rst=0, async): state=STOP, mode=000, braking=0, timeout=0, all counters 0, pending=000. req_ready=0 while rst=0.
- Direction class of a mode:
  - 000 and 111: STOP; 111 is treated as 000 when accepted.
  - 011, 101, 110: FWD.
  - 100: BACK.
  - 001: SPINA.
  - 010: SPINB.
- req_ready is combinational:
  - 0 if enable=0.
  - Else 1 if class(req_mode)=STOP.
  - Else 1 in STOP state.
  - Else 1 in RUN when hold_cnt==0.
  - Else 0, including all non-stop requests in BRAKE.
- Accept: req_valid & req_ready at a rising edge. mode changes on that same edge, so it is visible the next cycle (1-cycle latency).
- STOP:
  - Accept non-stop m → RUN, mode=m, hold_cnt=MIN_HOLD.
  - Accept stop → remain in STOP.
- RUN:
  - hold_cnt decrements to 0 and saturates there.
  - Accept stop → STOP, mode=000.
  - Accept m with the same class as current → mode=m, hold_cnt=MIN_HOLD.
  - Accept m with a different non-stop class → BRAKE, mode=000, pending=m, brake_cnt=DEAD_CYCLES-1, braking=1.
- BRAKE:
  - mode=000 for exactly DEAD_CYCLES cycles.
  - brake_cnt decrements each cycle.
  - On the cycle brake_cnt==0 → RUN, mode=pending, hold_cnt=MIN_HOLD, braking=0.
  - Accepted stop → STOP immediately, pending cleared. This wins over brake expiry in the same cycle.
- Watchdog:
  - wd_cnt clears on any cycle with req_valid=1 and increments otherwise, saturating.
  - When wd_cnt reaches TIMEOUT in RUN or BRAKE → STOP, mode=000, timeout=1, pending cleared.
  - wd_cnt does not trigger in STOP.
  - timeout clears on the next accepted non-stop request.
- enable=0:
  - Highest priority: next edge → STOP, mode=000, braking=0, counters cleared.
  - timeout is unchanged.
- Priority per edge: enable low > watchdog > accepted request > brake expiry > counter decrement.
- Counters never wrap; all comparisons are unsigned at CNT_W.

Test Plan (DEAD_CYCLES=4, MIN_HOLD=8, TIMEOUT=20):
- Reset, then req 011 held valid → req_ready=1, mode=011 one cycle after accept, state=1; a second 101 request stays not-ready for 8 cycles, then is accepted, mode=101, no brake.
- RUN 011 after dwell, req 100 → mode=000 and braking=1 for exactly 4 cycles, then mode=100, state=1, braking=0.
- In BRAKE (cycle 2), req 000 → accepted immediately, state=0, mode stays 000, pending 100 never appears.
- RUN 001, req_valid held low 20 cycles → on 20th cycle state=0, mode=000, timeout=1; next accepted 011 clears timeout.
- RUN 110, req 000 during dwell → accepted at once (ready=1), mode=000; req 111 from STOP → accepted, mode stays 000.
- enable=0 mid-BRAKE, then rst pulsed low mid-RUN → state=0, mode=000 within one edge / asynchronously on rst; req_ready=0 throughout.
